// File: rtl/lsu_addrchk_pipe.sv
// lsu_addrchk_pipe: dc1 address classification and fault checking, registered into dc2/dc3; fault log built when LSU_ADDRCHK_FAULT_LOG_EN is defined
module lsu_addrchk_pipe #(
  parameter int          NUM_WIN   = 8,
  parameter logic [31:0] DCCM_SADR = 32'hF004_0000,
  parameter int          DCCM_SIZE = 64,
  parameter logic [31:0] PIC_SADR  = 32'hF00C_0000,
  parameter int          PIC_SIZE  = 32,
  localparam int         WIDX_W    = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              req_valid,
  input  logic              req_dma,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       mrac,
  input  logic              win_we,
  input  logic [WIDX_W-1:0] win_idx,
  input  logic              win_en,
  input  logic [31:0]       win_addr,
  input  logic [31:0]       win_mask,
  input  logic              fault_clr,
  output logic              chk_valid_dc2,
  output logic              in_dccm_dc2,
  output logic              in_pic_dc2,
  output logic              external_dc2,
  output logic              access_fault_dc2,
  output logic              misaligned_dc2,
  output logic              sideeffects_dc2,
  output logic              sideeffects_dc3,
  output logic              fault_pend,
  output logic              fault_ovf,
  output logic [2:0]        fault_cause,
  output logic [31:0]       fault_addr
);
  localparam logic [31:0] DCCM_MASK = 32'(DCCM_SIZE * 1024 - 1);
  localparam logic [31:0] PIC_MASK  = 32'(PIC_SIZE * 1024 - 1);
  logic [NUM_WIN-1:0] win_en_q;
  logic [31:0]        win_addr_q [NUM_WIN];
  logic [31:0]        win_mask_q [NUM_WIN];
  logic [31:0] end_addr;
  logic chk, s_dccm, e_dccm, s_pic, e_pic, s_rgn, e_rgn;
  logic in_dccm, in_pic, ext, s_hit, e_hit, win_ok;
  logic c0, c1, c2, c3, c5, any_c, acc_f, mis, se, unal;
  assign chk      = req_valid & ~req_dma;
  assign end_addr = req_addr + (32'd1 << req_size) - 32'd1;
  assign s_dccm   = (req_addr & ~DCCM_MASK) == DCCM_SADR;
  assign e_dccm   = (end_addr & ~DCCM_MASK) == DCCM_SADR;
  assign s_pic    = (req_addr & ~PIC_MASK) == PIC_SADR;
  assign e_pic    = (end_addr & ~PIC_MASK) == PIC_SADR;
  assign s_rgn    = (req_addr[31:28] == DCCM_SADR[31:28]) | (req_addr[31:28] == PIC_SADR[31:28]);
  assign e_rgn    = (end_addr[31:28] == DCCM_SADR[31:28]) | (end_addr[31:28] == PIC_SADR[31:28]);
  assign in_dccm  = s_dccm & e_dccm;
  assign in_pic   = s_pic & e_pic;
  assign ext      = ~(in_dccm | in_pic);
  // A window must cover both ends of the access; an empty table permits everything
  always_comb begin
    s_hit = 1'b0;
    e_hit = 1'b0;
    for (int i = 0; i < NUM_WIN; i++) begin
      s_hit = s_hit | (win_en_q[i] & ((req_addr | win_mask_q[i]) == (win_addr_q[i] | win_mask_q[i])));
      e_hit = e_hit | (win_en_q[i] & ((end_addr | win_mask_q[i]) == (win_addr_q[i] | win_mask_q[i])));
    end
  end
  assign win_ok = ~|win_en_q | (s_hit & e_hit);
  assign c0     = (s_rgn & ~s_dccm & ~s_pic) | (e_rgn & ~e_dccm & ~e_pic);
  assign c1     = (s_dccm & e_pic) | (s_pic & e_dccm);
  assign c2     = (s_pic | e_pic) & ((req_size != 2'd2) | (|req_addr[1:0]));
  assign c3     = ~s_rgn & ~win_ok;
  assign c5     = &req_size;
  assign any_c  = c0 | c1 | c2 | c3 | c5;
  assign acc_f  = chk & any_c;
  assign unal   = (req_size == 2'd1) ? req_addr[0] : (req_size == 2'd2) ? |req_addr[1:0] : 1'b0;
  assign se     = chk & ~s_rgn & mrac[{req_addr[31:28], 1'b1}];
  assign mis    = chk & ext & ~any_c & ((req_addr[31:28] != end_addr[31:28]) | (se & unal));
  genvar g;
  generate
    for (g = 0; g < NUM_WIN; g++) begin : g_win
      // Window entry g; out-of-range indices never match any entry
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          win_en_q[g]   <= 1'b0;
          win_addr_q[g] <= '0;
          win_mask_q[g] <= '0;
        end else if (win_we && 32'(win_idx) == g) begin
          win_en_q[g]   <= win_en;
          win_addr_q[g] <= win_addr;
          win_mask_q[g] <= win_mask;
        end
    end
  endgenerate
  // dc2/dc3 pipeline registers, held while frozen
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      chk_valid_dc2    <= 1'b0;
      in_dccm_dc2      <= 1'b0;
      in_pic_dc2       <= 1'b0;
      external_dc2     <= 1'b1;
      access_fault_dc2 <= 1'b0;
      misaligned_dc2   <= 1'b0;
      sideeffects_dc2  <= 1'b0;
      sideeffects_dc3  <= 1'b0;
    end else if (!freeze) begin
      chk_valid_dc2    <= chk;
      in_dccm_dc2      <= in_dccm;
      in_pic_dc2       <= in_pic;
      external_dc2     <= ext;
      access_fault_dc2 <= acc_f;
      misaligned_dc2   <= mis;
      sideeffects_dc2  <= se;
      sideeffects_dc3  <= sideeffects_dc2;
    end
`ifdef LSU_ADDRCHK_FAULT_LOG_EN
  typedef enum logic {IDLE, PEND} state_t;
  state_t state, state_nxt;
  logic cap, log_en, ovf_nxt;
  logic [2:0] cause;
  assign cap   = ~freeze & (acc_f | mis);
  assign cause = c0 ? 3'd0 : c1 ? 3'd1 : c2 ? 3'd2 : c3 ? 3'd3 : c5 ? 3'd5 : 3'd4;
  // Fault log state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // A clear coinciding with a capture logs the new fault with overflow cleared
  always_comb begin
    log_en    = cap & ((state == IDLE) | fault_clr);
    state_nxt = (cap | ((state == PEND) & ~fault_clr)) ? PEND : IDLE;
    ovf_nxt   = ~fault_clr & (fault_ovf | (cap & (state == PEND)));
  end
  // Logged cause/address and overflow flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fault_ovf   <= 1'b0;
      fault_cause <= '0;
      fault_addr  <= '0;
    end else begin
      fault_ovf <= ovf_nxt;
      if (log_en) begin
        fault_cause <= cause;
        fault_addr  <= req_addr;
      end
    end
  assign fault_pend = state == PEND;
`else
  logic unused_clr;
  assign unused_clr  = fault_clr;
  assign fault_pend  = 1'b0;
  assign fault_ovf   = 1'b0;
  assign fault_cause = '0;
  assign fault_addr  = '0;
`endif
endmodule
